// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master (fetch/data) system bus arbiter.
package bus_arbiter_pkg;

  localparam int BUS_DATA_W = 32;
  localparam int BUS_MASK_W = 4;
  localparam int BUS_IRQ_W  = 6;

  localparam logic [BUS_DATA_W-1:0] BUS_ERR_WORD        = 32'hFFFF_FFFF;
  localparam int unsigned           BUS_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE,
    GNT_IF,
    GNT_D
  } BusArbState_t;

  typedef enum logic {
    MASTER_IF,
    MASTER_D
  } BusMaster_t;

  // On a tie the master that was not served most recently wins.
  function automatic BusMaster_t rr_winner(input logic req_if, input logic req_d,
                                           input BusMaster_t last);
    if (req_if && req_d) begin
      return (last == MASTER_IF) ? MASTER_D : MASTER_IF;
    end else if (req_d) begin
      return MASTER_D;
    end
    return MASTER_IF;
  endfunction

  function automatic BusArbState_t gnt_state(input BusMaster_t m);
    return (m == MASTER_D) ? GNT_D : GNT_IF;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Downstream system bus seen by the address decoder and peripherals.
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;

  logic [BUS_DATA_W-1:0] bus_address;
  logic [BUS_DATA_W-1:0] bus_data_wr;
  logic                  bus_read;
  logic                  bus_write;
  logic [BUS_MASK_W-1:0] bus_mask;
  logic                  bus_stall;
  logic [BUS_DATA_W-1:0] bus_data_rd;
  logic [BUS_DATA_W-1:0] bus_data_rd_2;
  logic [BUS_IRQ_W-1:0]  bus_interrupt;

  modport master (
    output bus_address, bus_data_wr, bus_read, bus_write, bus_mask,
    input  bus_stall, bus_data_rd, bus_data_rd_2, bus_interrupt
  );

  modport slave (
    input  bus_address, bus_data_wr, bus_read, bus_write, bus_mask,
    output bus_stall, bus_data_rd, bus_data_rd_2, bus_interrupt
  );

endinterface

// File: rtl/bus_arbiter_watchdog.sv
// Stall watchdog: counts stalled grant cycles and flags when the limit is reached.
module bus_watchdog
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = BUS_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [15:0] LIMIT   = 16'(TIMEOUT_CYCLES);
  localparam bit          ENABLED = (TIMEOUT_CYCLES != 0);

  logic [15:0] cnt_q, cnt_d;

  // Saturates so a disabled watchdog never wraps back to a small count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = ENABLED && (cnt_q == LIMIT);

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter between instruction fetch and data ports onto one system bus,
// with a stall watchdog that force-completes hung transactions.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned           TIMEOUT_CYCLES = BUS_TIMEOUT_DEFAULT,
  parameter logic [BUS_DATA_W-1:0] ERR_WORD       = BUS_ERR_WORD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BUS_DATA_W-1:0] if_address,
  input  logic                  if_read,
  output logic                  if_stall,
  output logic [BUS_DATA_W-1:0] if_data_rd,
  output logic [BUS_DATA_W-1:0] if_data_rd_2,
  input  logic [BUS_DATA_W-1:0] d_address,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [BUS_DATA_W-1:0] d_data_wr,
  input  logic [BUS_MASK_W-1:0] d_mask,
  output logic                  d_stall,
  output logic [BUS_DATA_W-1:0] d_data_rd,
  bus_arbiter_if.master         bus,
  output logic [BUS_IRQ_W-1:0]  interrupt,
  output logic                  timeout_err
);

  BusArbState_t state_q;
  BusMaster_t   last_q;
  BusMaster_t   served;
  BusMaster_t   win;

  logic req_if, req_d;
  logic gnt_if, gnt_d;
  logic req_gnt, expired, forced, complete, wd_clr;
  logic [BUS_DATA_W-1:0] rd_word, rd_word_2;

  assign req_if  = if_read;
  assign req_d   = d_read | d_write;
  assign gnt_if  = (state_q == GNT_IF);
  assign gnt_d   = (state_q == GNT_D);
  assign req_gnt = (gnt_if & req_if) | (gnt_d & req_d);

  assign forced   = req_gnt & expired;
  assign complete = req_gnt & (~bus.bus_stall | expired);
  assign served   = gnt_d ? MASTER_D : MASTER_IF;

  // A completing master already counts as most recently served for the next pick.
  assign win = rr_winner(req_if, req_d, complete ? served : last_q);

  // IDLE and dropped requests both clear the watchdog via ~req_gnt.
  assign wd_clr = ~req_gnt | complete;

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (wd_clr),
    .en_i     (bus.bus_stall),
    .expired_o(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= MASTER_IF;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_if || req_d) begin
            state_q <= gnt_state(win);
          end
        end
        GNT_IF, GNT_D: begin
          if (!req_gnt) begin
            state_q <= IDLE;
          end else if (complete) begin
            last_q  <= served;
            state_q <= gnt_state(win);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes track the live request so a withdrawn request leaves the bus at once.
  always_comb begin
    bus.bus_address = '0;
    bus.bus_data_wr = '0;
    bus.bus_read    = 1'b0;
    bus.bus_write   = 1'b0;
    bus.bus_mask    = '0;
    if (gnt_if) begin
      bus.bus_address = if_address;
      bus.bus_read    = if_read & ~expired;
      bus.bus_mask    = '1;
    end else if (gnt_d) begin
      bus.bus_address = d_address;
      bus.bus_data_wr = d_data_wr;
      bus.bus_read    = d_read & ~expired;
      bus.bus_write   = d_write & ~expired;
      bus.bus_mask    = d_mask;
    end
  end

  assign rd_word   = forced ? ERR_WORD : bus.bus_data_rd;
  assign rd_word_2 = forced ? ERR_WORD : bus.bus_data_rd_2;

  assign if_data_rd   = gnt_if ? rd_word   : '0;
  assign if_data_rd_2 = gnt_if ? rd_word_2 : '0;
  assign d_data_rd    = gnt_d  ? rd_word   : '0;

  assign if_stall = req_if & ~(gnt_if & complete);
  assign d_stall  = req_d  & ~(gnt_d  & complete);

  assign timeout_err = forced;
  assign interrupt   = bus.bus_interrupt;

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter placed between the CPU's instruction-fetch port and data-memory port and the single system bus master (the `Bus_if` master modport feeding the address decoder and peripherals). It grants the bus to one requester per transaction using round-robin order, holds the grant while the slave stalls, and forwards read data and stall back to the winner only. A watchdog force-completes any transaction the slave stalls too long, so a dead peripheral cannot hang the core.

## Interface
- `TIMEOUT_CYCLES`, default 255: stalled cycles before a forced completion; 0 disables the watchdog; 16-bit range.
- `ERR_WORD`, default 32'hFFFF_FFFF: read data returned on a forced completion.
- `clk` in 1: system clock; this is the `base` clock of `Clock_t`; single clock domain.
- `rst_n` in 1: reset, asynchronous and active-low.
- `if_address` in 32: instruction-fetch address.
- `if_read` in 1: instruction-fetch read request.
- `if_stall` out 1: stall to instruction fetch.
- `if_data_rd`, `if_data_rd_2` out 32: returned instruction words.
- `d_address` in 32: data-port address.
- `d_read`, `d_write` in 1: data-port read and write requests.
- `d_data_wr` in 32: data-port write data.
- `d_mask` in 4: data-port byte enables.
- `d_stall` out 1: stall to the data port.
- `d_data_rd` out 32: returned data word.
- `bus_address`, `bus_data_wr` out 32: downstream address and write data.
- `bus_read`, `bus_write` out 1: downstream strobes.
- `bus_mask` out 4: downstream byte enables.
- `bus_stall` in 1: downstream stall.
- `bus_data_rd`, `bus_data_rd_2` in 32: downstream read data.
- `bus_interrupt` in 6: interrupt lines from the bus; passed through.
- `interrupt` out 6: equals `bus_interrupt`, combinational.
- `timeout_err` out 1: one-cycle pulse on a forced completion.

## Operation
- A master is requesting when `if_read`, or `d_read | d_write`, is high.
- The fetch port always uses mask 4'b1111 and never writes.
- States:
  - IDLE: bus strobes, address, data and mask all driven 0.
  - GNT_IF: bus driven from the fetch port.
  - GNT_D: bus driven from the data port.
- IDLE with any request: move to the winner's GNT state on the next edge (one arbitration cycle).
- Round-robin rule: `last` holds the most recently served master. On a tie, the other master wins. Reset value of `last` is IF, so data wins the first tie.
- Completion happens in GNT_x when the requester's strobe is high and `bus_stall` is low:
  - the winner's stall is 0 that cycle and bus read data is forwarded to it;
  - `last` is updated to that master;
  - next state is the GNT of the round-robin winner among current requests, else IDLE;
  - a master holding its request after completion counts as a new request.
- Stall outputs, per port: stall = request AND NOT completing-for-this-port. A non-requesting port sees stall 0.
- Data outputs: the non-granted port's data outputs are 0.
- Requester drops its request while granted (protocol violation): bus strobes follow it to 0 immediately, and the state goes to IDLE next edge without updating `last`.
- Watchdog:
  - the counter increments each GNT cycle with `bus_stall` high, and clears on completion or IDLE;
  - when it reaches `TIMEOUT_CYCLES`, that cycle: bus strobes are forced 0, the winner's stall is 0, read data = `ERR_WORD`, and `timeout_err` = 1;
  - the transition then follows the normal completion rule.

## Timing
- Reset (async assert, sync release): state IDLE, `last` IF, counter 0, `timeout_err` 0, all bus outputs 0. Stall outputs follow the requests combinationally.
- With a zero-stall slave, a request completes in 2 cycles: arbitration, then access.
- Back-to-back transactions between alternating masters need no IDLE gap, giving 1 transaction per cycle after the first.
- Grant, state and counter are registered. Stall and data paths are combinational from `bus_stall` and `bus_data_rd`.
- A write is seen by the slave in every GNT_D cycle until it completes. Slaves must tolerate the repeated strobe.

## Structure
- Shared package holds:
  - `BusArbState_t` enum {IDLE, GNT_IF, GNT_D};
  - `BusMaster_t` enum {MASTER_IF, MASTER_D};
  - `BUS_ERR_WORD` and `BUS_TIMEOUT_DEFAULT` constants.
- One sub-module: `bus_watchdog`, the stall counter with clear, enable and `expired` output, parameterised by `TIMEOUT_CYCLES`.

## Test plan
- Fetch-only read at 0x1FC0_0000, slave zero-stall returning 0x2408_0001 → `bus_read` in cycle 1; `if_stall` 1,0; `if_data_rd` = 0x2408_0001 in cycle 1.
- Simultaneous fetch and data read after reset → data granted first. Fetch completes in the cycle directly after data completes (no IDLE); then `last` = IF.
- Data write 0x1234_5678 with mask 4'b0011 and slave stall for 3 cycles → bus strobes held 4 cycles with stable address, data and mask; `d_stall` 1 for 4 cycles, then 0.
- Both masters continuously requesting for 8 transactions → grants alternate D, IF, D, IF…; exactly 4 grants each.
- `TIMEOUT_CYCLES` = 4 and slave stalls forever → after 4 stalled cycles: one `timeout_err` pulse, `d_data_rd` = 0xFFFF_FFFF, then the next grant proceeds.
- `rst_n` asserted mid-GNT_D with stall → bus outputs 0 immediately, state IDLE; after release, arbitration restarts with data priority.
